// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the frame-buffer write path. Both the write scheduler
// and the pixel generators use these. It holds the default geometry, the
// background colour and the scheduler state encoding.
// -----------------------------------------------------------------------------
package fb_pkg;

  localparam int N_REQ    = 4;
  localparam int AW       = 16;
  localparam int DW       = 16;
  localparam int FB_WORDS = 19662;

  localparam logic [15:0] BG_COLOR = 16'h9249;

  typedef enum logic {
    SERVE = 1'b0,
    CLEAR = 1'b1
  } fb_state_t;

  // Width of a pointer that indexes n requesters. It is at least 1 bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. The scan starts at rr_ptr and moves
// upward, wrapping modulo N_REQ. The first asserted request it finds wins.
//
// Ports
//   req     in   N_REQ   request vector
//   rr_ptr  in   PW      requester index with highest priority this cycle
//   gnt     out  N_REQ   one-hot grant (all zero when no request)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N_REQ = fb_pkg::N_REQ,
  parameter int PW    = fb_pkg::ptr_width(fb_pkg::N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    rr_ptr,
  output logic [N_REQ-1:0] gnt
);

  import fb_pkg::*;

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PW'((int'(rr_ptr) + k) % N_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fb_write_scheduler.sv
// -----------------------------------------------------------------------------
// fb_write_scheduler
// Owns the single frame-buffer write port. Pixel writers share the port through
// round-robin arbitration. A frame_start pulse launches a background-clear
// sweep. The sweep writes BG_COLOR to every word, one word per clock, and it
// pre-empts all requesters while it runs.
//
// Ports
//   clk_2M       in   1          pixel clock
//   rst_n        in   1          asynchronous active-low reset
//   frame_start  in   1          pulse: start or restart the clear sweep
//   req          in   N_REQ      per-requester write request (held until gnt)
//   req_addr     in   N_REQ*AW   packed addresses, slice i = requester i
//   req_data     in   N_REQ*DW   packed pixel words, slice i = requester i
//   gnt          out  N_REQ      one-hot accept, same cycle as the winning req
//   clear_busy   out  1          high while the sweep is active
//   fb_we        out  1          registered RAM write enable
//   fb_addr      out  AW         registered RAM write address
//   fb_data      out  DW         registered RAM write data
//   err_oob      out  1          pulse: a granted write was out of range
// -----------------------------------------------------------------------------
module fb_write_scheduler #(
  parameter int N_REQ    = fb_pkg::N_REQ,
  parameter int AW       = fb_pkg::AW,
  parameter int DW       = fb_pkg::DW,
  parameter int FB_WORDS = fb_pkg::FB_WORDS,
  parameter logic [DW-1:0] BG_COLOR = fb_pkg::BG_COLOR
) (
  input  logic                  clk_2M,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*AW-1:0]   req_addr,
  input  logic [N_REQ*DW-1:0]   req_data,
  output logic [N_REQ-1:0]      gnt,
  output logic                  clear_busy,
  output logic                  fb_we,
  output logic [AW-1:0]         fb_addr,
  output logic [DW-1:0]         fb_data,
  output logic                  err_oob
);

  import fb_pkg::*;

  localparam int            PW        = ptr_width(N_REQ);
  localparam logic [AW-1:0] LAST_ADDR = AW'(FB_WORDS - 1);
  localparam logic [PW-1:0] LAST_PTR  = PW'(N_REQ - 1);

  fb_state_t          state;
  logic [AW-1:0]      clr_cnt;
  logic [PW-1:0]      rr_ptr;

  logic [N_REQ-1:0]   arb_gnt;
  logic               serve_ok;
  logic               any_gnt;
  logic [PW-1:0]      win_idx;
  logic [PW-1:0]      next_ptr;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_data;
  logic               sel_oob;
  logic [AW-1:0]      cnt_eff;
  logic               sweep_last;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr),
    .gnt    (arb_gnt)
  );

  // Grants are only issued in SERVE. They are also held off during reset and
  // in the cycle where frame_start is sampled, because the sweep wins that
  // cycle.
  assign serve_ok = rst_n && (state == SERVE) && !frame_start;
  assign gnt      = serve_ok ? arb_gnt : '0;
  assign any_gnt  = |gnt;

  // Select the winner's index, address and data from the one-hot grant.
  always_comb begin
    win_idx  = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        win_idx  = PW'(i);
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  assign next_ptr = (win_idx == LAST_PTR) ? '0 : win_idx + PW'(1);
  assign sel_oob  = sel_addr > LAST_ADDR;

  // A frame_start during a sweep restarts it in the same cycle. The word
  // written that cycle is address 0, so no cycle is lost.
  assign cnt_eff    = frame_start ? '0 : clr_cnt;
  assign sweep_last = (cnt_eff == LAST_ADDR);

  always_ff @(posedge clk_2M or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SERVE;
      clr_cnt    <= '0;
      rr_ptr     <= '0;
      clear_busy <= 1'b0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= '0;
      err_oob    <= 1'b0;
    end else begin
      fb_we      <= 1'b0;
      err_oob    <= 1'b0;
      // Busy covers the sweep plus the cycle that presents its final write.
      clear_busy <= frame_start || (state == CLEAR);
      case (state)
        SERVE: begin
          if (frame_start) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end else if (any_gnt) begin
            rr_ptr <= next_ptr;
            if (sel_oob) begin
              // The request is consumed, but the write is not performed.
              // fb_addr and fb_data keep their previous values.
              err_oob <= 1'b1;
            end else begin
              fb_we   <= 1'b1;
              fb_addr <= sel_addr;
              fb_data <= sel_data;
            end
          end
        end
        CLEAR: begin
          fb_we   <= 1'b1;
          fb_addr <= cnt_eff;
          fb_data <= BG_COLOR;
          if (sweep_last) begin
            state   <= SERVE;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= cnt_eff + AW'(1);
          end
        end
        default: begin
          state <= SERVE;
        end
      endcase
    end
  end

endmodule
